axil_reg_bank: RTL and testbench
================================

Name: axil_reg_bank

Overview:
- Parametrised AXI4-Lite slave register bank, successor to the fixed word-addressed control/status register block.
- Adds byte addressing, write strobes, SLVERR decode, per-register write pulses and configurable sign/zero extension of narrow registers.
- Sits between the host AXI-Lite interconnect and DSP datapath blocks; exposes N_CTL control outputs and N_STS status inputs.

Parameters:
- CFGAW, 32, AXI-Lite address width.
- CFGDW, 32, AXI-Lite data width (32 or 64).
- REGW, 32, register width; must satisfy 1 <= REGW <= CFGDW.
- N_CTL, 32, number of control registers (read/write).
- N_STS, 32, number of status registers (read-only).
- SIGN_EXTEND, 1, 1 = sign-extend REGW to CFGDW on read; 0 = zero-extend.
- CTL_INIT, 0, reset value of every ctl_regs entry (REGW bits).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axil_awaddr/awvalid/awready  in/in/out  CFGAW/1/1  write address channel.
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  CFGDW/CFGDW/8/1/1  write data channel.
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axil_araddr/arvalid/arready  in/in/out  CFGAW/1/1  read address channel.
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  CFGDW/2/1/1  read response channel.
- ctl_regs  out  REGW x N_CTL  control register contents.
- ctl_wr  out  N_CTL  one-cycle pulse per control register written.
- sts_regs  in  REGW x N_STS  status inputs.

Behaviour:
- Reset (rst_n low, async): bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, ctl_regs=CTL_INIT, ctl_wr=0; all skids empty. Ready outputs are deasserted while in reset.
- Addressing: word index = addr >> log2(CFGDW/8); low address bits are ignored. Indexes 0..N_CTL-1 are control registers; N_CTL..N_CTL+N_STS-1 are status registers; all other indexes are unmapped.
- AW, W and AR each pass through a 2-entry skid buffer; ready = not full, so each channel sustains one transfer per cycle.
- Write commit when AW-skid valid, W-skid valid, and (!bvalid || bready). Both skids pop in the same cycle. bvalid rises on the edge after the commit. Channel ordering between AW and W is arbitrary.
- Control write: each byte lane with wstrb set replaces the matching bits of ctl_regs[idx]; lanes at or above REGW are dropped. ctl_wr[idx] pulses for one cycle, coincident with the update. bresp=OKAY.
- Write to a status or unmapped index: no register change, no pulse, bresp=SLVERR (2'b10).
- Write with wstrb=0: OKAY response, register unchanged, ctl_wr still pulses.
- Read commit when AR-skid valid and (!rvalid || rready). rdata is sampled at the commit and is stable while rvalid is high. rresp=OKAY for mapped indexes. Unmapped reads return rdata=0 and rresp=SLVERR.
- Read extension is set by SIGN_EXTEND.
- Simultaneous write commit and read of the same control register: the read returns the pre-write value.
- Back-to-back throughput: one write and one read per cycle with bready and rready held high.
- Reset asserted mid-transaction: the outstanding response is discarded and no partial register update occurs.

Optional Feature:
- Macro: AXIL_REG_BANK_STICKY_EN.
- Defined: each status register is a sticky latch, sticky[i] |= sts_regs[i] every cycle. Reads return the sticky value. A write to a status index clears the strobed bits that are written as 1 (write-1-to-clear) and returns OKAY. The clear takes priority over a same-cycle set. Sticky latches reset to 0.
- Undefined: status reads return live sts_regs; status writes return SLVERR.

Decomposition:
- Shared package axil_pkg: resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10) and a function returning the word-index shift from CFGDW.
- One sub-module, axil_skid: parametrised DW, 2-entry skid buffer, instantiated three times.

Test Plan:
- Write 0xDEADBEEF to byte addr 0x08 with wstrb=0xF, then read 0x08 -> bresp=0, ctl_regs[2]=0xDEADBEEF, ctl_wr[2] pulses once, rdata=0xDEADBEEF.
- Write 0x000000AA to addr 0x04 with wstrb=0x1 over prior value 0x12345678 -> ctl_regs[1]=0x123456AA.
- REGW=16, SIGN_EXTEND=1, sts_regs[0]=0x8001; read addr N_CTL*4 -> rdata=0xFFFF8001. With SIGN_EXTEND=0 -> rdata=0x00008001.
- Read at index N_CTL+N_STS, then write to a status index -> rresp=2'b10 with rdata=0; bresp=2'b10; no ctl_wr pulse.
- W sent 3 cycles before AW, with bready held low for 5 cycles -> single commit, bvalid held, AW/W skids fill and ready drops; no transfer is lost.
- STICKY_EN: pulse sts_regs[0]=0x4 for 1 cycle, read -> 0x4; write 0x4 -> read returns 0x0.

Source files
------------

// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite response codes and address-to-word-index helper
package axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic int word_shift(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/axil_skid.sv
// axil_skid: 2-entry skid buffer (ready = not full, one transfer per cycle)
// Ports: clk, rst_n (async active-low); in_data/in_valid/in_ready upstream;
// out_data/out_valid/out_ready downstream. in_ready is low while in reset.
module axil_skid import axil_pkg::*; #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);
  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [1:0]    cnt_q, cnt_d, wi;
  logic          push, pop;
  assign in_ready  = rst_n & (cnt_q != 2'd2);
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = d0_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // incoming word lands in the slot left free after this cycle's pop
  always_comb begin
    wi    = cnt_q - {1'b0, pop};
    d0_d  = (push && wi == 2'd0) ? in_data : pop ? d1_q : d0_q;
    d1_d  = (push && wi == 2'd1) ? in_data : d1_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q  <= '0;
      d1_q  <= '0;
      cnt_q <= '0;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite slave with N_CTL r/w control and N_STS read-only status registers
// Ports: clk, rst_n (async active-low); s_axil_aw*/w*/b*/ar*/r* AXI-Lite slave;
// ctl_regs (register contents), ctl_wr (one-cycle write pulse per register), sts_regs (status in).
// Optional: define AXIL_REG_BANK_STICKY_EN for sticky, write-1-to-clear status registers.
module axil_reg_bank import axil_pkg::*; #(
  parameter int               CFGAW       = 32,
  parameter int               CFGDW       = 32,
  parameter int               REGW        = 32,
  parameter int               N_CTL       = 32,
  parameter int               N_STS       = 32,
  parameter bit               SIGN_EXTEND = 1'b1,
  parameter logic [REGW-1:0]  CTL_INIT    = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CFGAW-1:0]            s_axil_awaddr,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [CFGDW-1:0]            s_axil_wdata,
  input  logic [CFGDW/8-1:0]          s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,
  input  logic [CFGAW-1:0]            s_axil_araddr,
  input  logic                        s_axil_arvalid,
  output logic                        s_axil_arready,
  output logic [CFGDW-1:0]            s_axil_rdata,
  output logic [1:0]                  s_axil_rresp,
  output logic                        s_axil_rvalid,
  input  logic                        s_axil_rready,
  output logic [N_CTL-1:0][REGW-1:0]  ctl_regs,
  output logic [N_CTL-1:0]            ctl_wr,
  input  logic [N_STS-1:0][REGW-1:0]  sts_regs
);
  localparam int SH = word_shift(CFGDW);
  localparam int SW = CFGDW / 8;
  logic                       aw_v, w_v, ar_v, wr_go, rd_go, w_ok, r_ok;
  logic [CFGAW-1:0]           aw_a, ar_a, widx, ridx;
  logic [CFGDW-1:0]           w_d, rext;
  logic [SW-1:0]              w_s;
  logic [REGW-1:0]            rval;
  logic [N_STS-1:0][REGW-1:0] sv;
  logic [N_CTL-1:0][REGW-1:0] ctl_q, ctl_d;
  logic [N_CTL-1:0]           wr_q, wr_d;
  logic                       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
  logic [CFGDW-1:0]           rdata_q, rdata_d;
  // byte lanes beyond REGW have no register bits and fall away here
  function automatic logic [REGW-1:0] merge(input logic [REGW-1:0] old,
                                            input logic [CFGDW-1:0] d,
                                            input logic [SW-1:0] s);
    merge = old;
    for (int b = 0; b < REGW; b++) if (s[b/8]) merge[b] = d[b];
  endfunction
  axil_skid #(.DW(CFGAW)) u_aw (
    .clk, .rst_n,
    .in_data(s_axil_awaddr), .in_valid(s_axil_awvalid), .in_ready(s_axil_awready),
    .out_data(aw_a), .out_valid(aw_v), .out_ready(wr_go)
  );
  axil_skid #(.DW(CFGDW + SW)) u_w (
    .clk, .rst_n,
    .in_data({s_axil_wstrb, s_axil_wdata}), .in_valid(s_axil_wvalid), .in_ready(s_axil_wready),
    .out_data({w_s, w_d}), .out_valid(w_v), .out_ready(wr_go)
  );
  axil_skid #(.DW(CFGAW)) u_ar (
    .clk, .rst_n,
    .in_data(s_axil_araddr), .in_valid(s_axil_arvalid), .in_ready(s_axil_arready),
    .out_data(ar_a), .out_valid(ar_v), .out_ready(rd_go)
  );
  assign wr_go = aw_v & w_v & (~bvalid_q | s_axil_bready);
  assign rd_go = ar_v & (~rvalid_q | s_axil_rready);
  assign widx  = aw_a >> SH;
  assign ridx  = ar_a >> SH;
`ifdef AXIL_REG_BANK_STICKY_EN
  logic [N_STS-1:0][REGW-1:0] sticky_q, sticky_d;
  // a same-cycle clear wins over a new set
  always_comb begin
    sticky_d = sticky_q;
    for (int i = 0; i < N_STS; i++)
      sticky_d[i] = (sticky_q[i] | sts_regs[i]) &
                    ~((wr_go && widx == CFGAW'(N_CTL + i)) ? merge('0, w_d, w_s) : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end
  assign sv = sticky_q;
`else
  assign sv = sts_regs;
`endif
  always_comb begin
    ctl_d = ctl_q;
    wr_d  = '0;
    w_ok  = 1'b0;
    for (int i = 0; i < N_CTL; i++)
      if (widx == CFGAW'(i)) begin
        w_ok = 1'b1;
        if (wr_go) begin
          ctl_d[i] = merge(ctl_q[i], w_d, w_s);
          wr_d[i]  = 1'b1;
        end
      end
`ifdef AXIL_REG_BANK_STICKY_EN
    for (int i = 0; i < N_STS; i++)
      if (widx == CFGAW'(N_CTL + i)) w_ok = 1'b1;
`endif
    bresp_d  = wr_go ? (w_ok ? RESP_OKAY : RESP_SLVERR) : bresp_q;
    bvalid_d = wr_go | (bvalid_q & ~s_axil_bready);
  end
  // reads see ctl_q, so a same-cycle write to the same register is not yet visible
  always_comb begin
    rval = '0;
    r_ok = 1'b0;
    for (int i = 0; i < N_CTL; i++)
      if (ridx == CFGAW'(i)) begin
        rval = ctl_q[i];
        r_ok = 1'b1;
      end
    for (int i = 0; i < N_STS; i++)
      if (ridx == CFGAW'(N_CTL + i)) begin
        rval = sv[i];
        r_ok = 1'b1;
      end
    rext     = SIGN_EXTEND ? CFGDW'($signed(rval)) : CFGDW'(rval);
    rdata_d  = rd_go ? (r_ok ? rext : '0) : rdata_q;
    rresp_d  = rd_go ? (r_ok ? RESP_OKAY : RESP_SLVERR) : rresp_q;
    rvalid_d = rd_go | (rvalid_q & ~s_axil_rready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q    <= {N_CTL{CTL_INIT}};
      wr_q     <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      ctl_q    <= ctl_d;
      wr_q     <= wr_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end
  assign ctl_regs      = ctl_q;
  assign ctl_wr        = wr_q;
  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rresp  = rresp_q;
  assign s_axil_rdata  = rdata_q;
endmodule

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank: scoreboard bench driving three bank configurations with identical traffic
module tb_axil_reg_bank;
  typedef struct packed {logic [1:0] resp; logic [31:0] a, b, c;} rexp_t;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;
`ifdef AXIL_REG_BANK_STICKY_EN
  localparam logic [1:0] STS_WR = OK;
`else
  localparam logic [1:0] STS_WR = SE;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic [2:0]  awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp [3];
  logic [1:0]  rresp [3];
  logic [31:0] rdata [3];
  logic [3:0]  ctl_wr [3];
  logic [3:0][31:0] ctl_a;
  logic [3:0][15:0] ctl_b, ctl_c;
  logic [1:0][31:0] sts_a;
  logic [1:0][15:0] sts_b;
  logic [1:0]  bq[$];
  rexp_t       rq[$];
  logic [1:0]  be;
  rexp_t       re;
  int vec_n = 0, miss_n = 0, cyc = 0;
  int wr_cnt [4] = '{0, 0, 0, 0};
  axil_reg_bank #(.CFGAW(32), .CFGDW(32), .REGW(32), .N_CTL(4), .N_STS(2), .SIGN_EXTEND(1'b1)) u_a (
    .clk, .rst_n,
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready[0]),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready[0]),
    .s_axil_bresp(bresp[0]), .s_axil_bvalid(bvalid[0]), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready[0]),
    .s_axil_rdata(rdata[0]), .s_axil_rresp(rresp[0]), .s_axil_rvalid(rvalid[0]), .s_axil_rready(rready),
    .ctl_regs(ctl_a), .ctl_wr(ctl_wr[0]), .sts_regs(sts_a)
  );
  axil_reg_bank #(.CFGAW(32), .CFGDW(32), .REGW(16), .N_CTL(4), .N_STS(2), .SIGN_EXTEND(1'b1)) u_b (
    .clk, .rst_n,
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready[1]),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready[1]),
    .s_axil_bresp(bresp[1]), .s_axil_bvalid(bvalid[1]), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready[1]),
    .s_axil_rdata(rdata[1]), .s_axil_rresp(rresp[1]), .s_axil_rvalid(rvalid[1]), .s_axil_rready(rready),
    .ctl_regs(ctl_b), .ctl_wr(ctl_wr[1]), .sts_regs(sts_b)
  );
  axil_reg_bank #(.CFGAW(32), .CFGDW(32), .REGW(16), .N_CTL(4), .N_STS(2), .SIGN_EXTEND(1'b0)) u_c (
    .clk, .rst_n,
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready[2]),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready[2]),
    .s_axil_bresp(bresp[2]), .s_axil_bvalid(bvalid[2]), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready[2]),
    .s_axil_rdata(rdata[2]), .s_axil_rresp(rresp[2]), .s_axil_rvalid(rvalid[2]), .s_axil_rready(rready),
    .ctl_regs(ctl_c), .ctl_wr(ctl_wr[2]), .sts_regs(sts_b)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) for (int i = 0; i < 4; i++) if (ctl_wr[0][i]) wr_cnt[i]++;
  always @(negedge clk) if (rst_n) begin
    if (bvalid[0] && bready) begin
      if (bq.size() == 0) begin
        vec_n++; miss_n++;
        $display("FAIL b_unexpected: got bresp %0h, expected no response", bresp[0]);
      end else begin
        be = bq.pop_front();
        chk("bresp_a", bresp[0], be);
        chk("bresp_b", bresp[1], be);
        chk("bresp_c", bresp[2], be);
        chk("bvalid_bc", bvalid[2:1], 2'b11);
      end
    end
    if (rvalid[0] && rready) begin
      if (rq.size() == 0) begin
        vec_n++; miss_n++;
        $display("FAIL r_unexpected: got rdata %0h, expected no response", rdata[0]);
      end else begin
        re = rq.pop_front();
        chk("rresp_a", rresp[0], re.resp);
        chk("rresp_b", rresp[1], re.resp);
        chk("rresp_c", rresp[2], re.resp);
        chk("rdata_a", rdata[0], re.a);
        chk("rdata_b", rdata[1], re.b);
        chk("rdata_c", rdata[2], re.c);
      end
    end
  end
  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready[0] && n < 200);
    chk("aw_accept", awready[0], 1'b1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!wready[0] && n < 200);
    chk("w_accept", wready[0], 1'b1);
    @(posedge clk); #1 wvalid = 1'b0;
  endtask
  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready[0] && n < 200);
    chk("ar_accept", arready[0], 1'b1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] e);
    bq.push_back(e);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask
  task automatic rd(input logic [31:0] a, input rexp_t e);
    rq.push_back(e);
    send_ar(a);
  endtask
  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 500) begin @(negedge clk); n++; end
    chk("drain", bq.size() + rq.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int s0, c0;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    sts_a = '0; sts_b = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_awready", awready, 3'b000);
    chk("rst_wready", wready, 3'b000);
    chk("rst_arready", arready, 3'b000);
    chk("rst_bvalid", bvalid, 3'b000);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_bresp", bresp[0], 2'b00);
    chk("rst_rresp", rresp[0], 2'b00);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_ctl", ctl_a, 128'h0);
    chk("rst_ctl_wr", ctl_wr[0], 4'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr(32'h08, 32'hDEADBEEF, 4'hF, OK);
    rd(32'h08, '{OK, 32'hDEADBEEF, 32'hFFFFBEEF, 32'h0000BEEF});
    drain();
    chk("ctl2_a", ctl_a[2], 32'hDEADBEEF);
    chk("ctl2_b", ctl_b[2], 16'hBEEF);
    chk("ctl_wr2_once", wr_cnt[2], 1);
    wr(32'h04, 32'h12345678, 4'hF, OK);
    wr(32'h04, 32'h000000AA, 4'h1, OK);
    rd(32'h04, '{OK, 32'h123456AA, 32'h000056AA, 32'h000056AA});
    rd(32'h0B, '{OK, 32'hDEADBEEF, 32'hFFFFBEEF, 32'h0000BEEF});
    drain();
    chk("ctl1_strb", ctl_a[1], 32'h123456AA);
    chk("ctl1_c", ctl_c[1], 16'h56AA);
    sts_a[0] = 32'h8001; sts_b[0] = 16'h8001;
    rd(32'h10, '{OK, 32'h00008001, 32'hFFFF8001, 32'h00008001});
    s0 = wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3];
    rd(32'h18, '{SE, 32'h0, 32'h0, 32'h0});
    wr(32'h10, 32'h0, 4'hF, STS_WR);
    wr(32'h18, 32'hFFFFFFFF, 4'hF, SE);
    drain();
    chk("err_no_pulse", wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3], s0);
    chk("err_no_change", ctl_a, {32'h0, 32'hDEADBEEF, 32'h123456AA, 32'h0});
    wr(32'h08, 32'hFFFFFFFF, 4'h0, OK);
    drain();
    chk("strb0_keep", ctl_a[2], 32'hDEADBEEF);
    chk("strb0_pulse", wr_cnt[2], 2);
    wr(32'h0C, 32'h11111111, 4'hF, OK);
    drain();
    bq.push_back(OK);
    rq.push_back('{OK, 32'h11111111, 32'h00001111, 32'h00001111});
    fork
      send_aw(32'h0C);
      send_w(32'h22222222, 4'hF);
      send_ar(32'h0C);
    join
    rd(32'h0C, '{OK, 32'h22222222, 32'h00002222, 32'h00002222});
    drain();
    bready = 1'b0;
    bq.push_back(OK);
    fork
      begin
        send_w(32'hCAFEF00D, 4'hF);
        @(negedge clk);
        chk("w_only_no_b", bvalid[0], 1'b0);
      end
      begin
        repeat (3) @(posedge clk); #1;
        send_aw(32'h08);
      end
    join
    bq.push_back(OK);
    bq.push_back(OK);
    fork
      begin send_aw(32'h00); send_aw(32'h00); end
      begin send_w(32'h1, 4'hF); send_w(32'h2, 4'hF); end
    join
    @(negedge clk);
    chk("full_awready", awready[0], 1'b0);
    chk("full_wready", wready[0], 1'b0);
    chk("held_bvalid", bvalid[0], 1'b1);
    repeat (2) @(posedge clk); #1;
    bready = 1'b1;
    drain();
    chk("bp_ctl0", ctl_a[0], 32'h2);
    chk("bp_ctl2", ctl_a[2], 32'hCAFEF00D);
    chk("bp_pulses0", wr_cnt[0], 2);
    for (int k = 0; k < 4; k++) begin
      bq.push_back(OK);
      rq.push_back('{OK, 32'h00008001, 32'hFFFF8001, 32'h00008001});
    end
    c0 = cyc;
    fork
      for (int k = 0; k < 4; k++) send_aw(32'(k * 4));
      for (int k = 0; k < 4; k++) send_w(32'(k), 4'hF);
      for (int k = 0; k < 4; k++) send_ar(32'h10);
    join
    chk("b2b_cycles", cyc - c0, 4);
    drain();
    chk("b2b_ctl", ctl_a, {32'd3, 32'd2, 32'd1, 32'd0});
`ifdef AXIL_REG_BANK_STICKY_EN
    sts_a[1] = 32'h4; sts_b[1] = 16'h4;
    @(posedge clk); #1;
    sts_a[1] = 32'h0; sts_b[1] = 16'h0;
    rd(32'h14, '{OK, 32'h4, 32'h4, 32'h4});
    wr(32'h14, 32'h4, 4'hF, OK);
    rd(32'h14, '{OK, 32'h0, 32'h0, 32'h0});
    drain();
`endif
    bready = 1'b0;
    fork
      send_aw(32'h04);
      send_w(32'h99, 4'hF);
    join
    begin
      int n = 0;
      while (!bvalid[0] && n < 50) begin @(negedge clk); n++; end
    end
    chk("pre_rst_bvalid", bvalid[0], 1'b1);
    send_aw(32'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", bvalid, 3'b000);
    chk("mid_rst_ctl", ctl_a, 128'h0);
    chk("mid_rst_ctl_wr", ctl_wr[0], 4'h0);
    chk("mid_rst_awready", awready[0], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    send_w(32'h77, 4'hF);
    repeat (3) @(negedge clk);
    chk("skid_flushed", bvalid[0], 1'b0);
    @(posedge clk); #1;
    bq.push_back(OK);
    send_aw(32'h08);
    drain();
    chk("post_rst_ctl2", ctl_a[2], 32'h77);
    chk("post_rst_ctl1", ctl_a[1], 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end
endmodule
